char_rom_arb: RTL and testbench

CHAR_ROM_ARB -- requirements
Module: char_rom_arb

---
 rtl/char_rom_arb_pkg.sv | 11 +
 rtl/char_rom_arb_rr.sv | 30 +++
 rtl/char_rom_arb.sv | 102 ++++++++++
 tb/tb_char_rom_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/char_rom_arb_pkg.sv
// Shared constants for the character-ROM arbiter slice.
package char_rom_pkg;

    localparam int unsigned CHAR_ADDR_W  = 10;
    localparam int unsigned CHAR_DATA_W  = 144;
    localparam int unsigned CHAR_ROM_LAT = 1;

    // Flops in the rom_rst release synchronizer.
    localparam int unsigned RST_SYNC_LEN = 2;

endpackage

// File: rtl/char_rom_arb_rr.sv
// Round-robin one-hot grant: the search starts just after ptr and wraps to 0.
module rr_arbiter
    import char_rom_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Offset NUM_REQ lands back on ptr itself, so it has the lowest priority.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/char_rom_arb.sv
// Shares one character ROM between NUM_REQ requesters; responses return
// in acceptance order, ROM_LAT+1 cycles after each grant.
module char_rom_arb
    import char_rom_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = CHAR_ADDR_W,
    parameter int unsigned DATA_W  = CHAR_DATA_W,
    parameter int unsigned ROM_LAT = CHAR_ROM_LAT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_rst,
    input  logic [DATA_W-1:0]         rom_rd_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [RST_SYNC_LEN-1:0] rst_sync;
    logic [PTR_W-1:0]        ptr;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      accepted;
    logic [PTR_W-1:0]        win_idx;
    logic [ADDR_W-1:0]       win_addr;
    logic [NUM_REQ-1:0]      id_pipe [ROM_LAT+1];

    // Set asynchronously, cleared only after RST_SYNC_LEN clean edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '1;
        end else begin
            rst_sync <= {rst_sync[RST_SYNC_LEN-2:0], 1'b0};
        end
    end

    assign rom_rst = rst_sync[RST_SYNC_LEN-1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = rom_rst ? '0 : grant;
    assign accepted  = req_valid & req_ready;

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx  = PTR_W'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            rom_addr <= '0;
        end else if (|accepted) begin
            ptr      <= win_idx;
            rom_addr <= win_addr;
        end
    end

    // Stage s holds the requester whose read was accepted s+1 edges ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s <= ROM_LAT; s++) begin
                id_pipe[s] <= '0;
            end
        end else begin
            id_pipe[0] <= accepted;
            for (int unsigned s = 1; s <= ROM_LAT; s++) begin
                id_pipe[s] <= id_pipe[s-1];
            end
        end
    end

    assign rsp_valid = id_pipe[ROM_LAT];
    assign rsp_data  = rom_rd_data;

    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s <= ROM_LAT; s++) begin
            busy = busy | (|id_pipe[s]);
        end
    end

endmodule

// File: tb/tb_char_rom_arb.sv
// Bench for char_rom_arb: ROM_LAT=1 and ROM_LAT=2 instances share stimulus
// and are checked against a cycle-history reference model.
module tb_char_rom_arb;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   req_valid;
    logic [39:0]  req_addr;

    logic [3:0]   rdy1, rdy2, rv1, rv2;
    logic [9:0]   ra1, ra2;
    logic         rr1, rr2, busy1, busy2;
    logic [143:0] rd1, rd2, rd2_q, rsp1, rsp2;

    int           n_cmp = 0;
    int           n_err = 0;

    // Reference model: grant per cycle (-1 = none) and the granted address.
    int           hist_g [2048];
    logic [9:0]   hist_a [2048];
    int           cyc       = 0;
    int           ptr       = 0;
    int           rst_cnt   = 0;
    int           last_g    = -1;
    logic [9:0]   last_addr = '0;

    always #5 clk = ~clk;

    function automatic logic [143:0] rom_word(input logic [9:0] a);
        logic [17:0] w;
        w = {a, a[7:0]} ^ 18'h2A5C3;
        return {w, ~w, w ^ 18'h15555, w, ~w, w, w ^ 18'h0F0F0, ~w};
    endfunction

    char_rom_arb #(
        .NUM_REQ (4),
        .ADDR_W  (10),
        .DATA_W  (144),
        .ROM_LAT (1)
    ) u_l1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (rdy1),
        .rom_addr    (ra1),
        .rom_rst     (rr1),
        .rom_rd_data (rd1),
        .rsp_valid   (rv1),
        .rsp_data    (rsp1),
        .busy        (busy1)
    );

    char_rom_arb #(
        .NUM_REQ (4),
        .ADDR_W  (10),
        .DATA_W  (144),
        .ROM_LAT (2)
    ) u_l2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (rdy2),
        .rom_addr    (ra2),
        .rom_rst     (rr2),
        .rom_rd_data (rd2),
        .rsp_valid   (rv2),
        .rsp_data    (rsp2),
        .busy        (busy2)
    );

    // External ROMs: one read register, or read register plus output register.
    always_ff @(posedge clk or posedge rr1) begin
        if (rr1) rd1 <= '0;
        else     rd1 <= rom_word(ra1);
    end

    always_ff @(posedge clk or posedge rr2) begin
        if (rr2) begin
            rd2_q <= '0;
            rd2   <= '0;
        end else begin
            rd2_q <= rom_word(ra2);
            rd2   <= rd2_q;
        end
    end

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_inst(input string tn, input int lat, input logic [3:0] eg,
                              input logic [3:0] rdy, input logic [3:0] rv,
                              input logic bsy, input logic rrst,
                              input logic [9:0] ra, input logic [143:0] rsp);
        int         src;
        logic [3:0] erv;
        logic       eb;
        src = cyc - lat - 1;
        erv = '0;
        if (src >= 0 && hist_g[src] >= 0) erv = 4'(1 << hist_g[src]);
        eb = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            if (cyc - k >= 0 && hist_g[cyc-k] >= 0) eb = 1'b1;
        end
        chk({tn, ".req_ready"}, 144'(rdy), 144'(eg));
        chk({tn, ".rsp_valid"}, 144'(rv), 144'(erv));
        chk({tn, ".busy"}, 144'(bsy), 144'(eb));
        chk({tn, ".rom_rst"}, 144'(rrst), 144'(rst_cnt < 2));
        chk({tn, ".rom_addr"}, 144'(ra), 144'(last_addr));
        if (erv != 4'h0) chk({tn, ".rsp_data"}, rsp, rom_word(hist_a[src]));
    endtask

    // One clock: check at negedge+1, then advance the model past the rising edge.
    task automatic step();
        int         g;
        logic [3:0] eg;
        #1;
        if (!rst_n) begin
            for (int j = 0; j < 2048; j++) hist_g[j] = -1;
            ptr       = 0;
            last_addr = '0;
            rst_cnt   = 0;
        end
        g = -1;
        if (rst_n && rst_cnt >= 2) begin
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && req_valid[(ptr + k) % 4]) g = (ptr + k) % 4;
            end
        end
        eg = (g >= 0) ? 4'(1 << g) : 4'h0;
        check_inst("l1", 1, eg, rdy1, rv1, busy1, rr1, ra1, rsp1);
        check_inst("l2", 2, eg, rdy2, rv2, busy2, rr2, ra2, rsp2);
        @(posedge clk);
        #1;
        hist_g[cyc] = g;
        if (g >= 0) begin
            hist_a[cyc]  = req_addr[g*10 +: 10];
            ptr          = g;
            last_addr    = hist_a[cyc];
            req_valid[g] = 1'b0;
        end
        if (rst_n && rst_cnt < 2) rst_cnt++;
        last_g = g;
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_addr(input int i, input logic [9:0] a);
        req_addr[i*10 +: 10] = a;
    endtask

    task automatic idle(input int n);
        req_valid = 4'h0;
        repeat (n) step();
    endtask

    function automatic logic [9:0] pick_addr();
        case ($urandom_range(3, 0))
            0:       return 10'h000;
            1:       return 10'h3FF;
            default: return 10'($urandom);
        endcase
    endfunction

    initial begin
        for (int j = 0; j < 2048; j++) hist_g[j] = -1;
        req_valid = 4'h0;
        req_addr  = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;

        // Single request 0x041 from requester 0; held off while rom_rst is high.
        set_addr(0, 10'h041);
        req_valid = 4'b0001;
        repeat (3) step();
        idle(4);

        // All four requesting for 8 cycles starting from pointer 0.
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'hF;
            step();
            if (last_g >= 0) set_addr(last_g, 10'($urandom));
        end
        idle(4);

        // Lone requester 2, back-to-back addresses 0..4.
        for (int k = 0; k < 5; k++) begin
            set_addr(2, 10'(k));
            req_valid = 4'b0100;
            step();
        end
        idle(4);

        // Requesters 0 and 3 alternate.
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'b1001;
            step();
            if (last_g >= 0) set_addr(last_g, 10'($urandom));
        end
        idle(4);

        // Reset one cycle after two acceptances, then requester 0 alone.
        set_addr(0, 10'h123);
        set_addr(1, 10'h2AB);
        req_valid = 4'b0011;
        step();
        step();
        req_valid = 4'h0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_addr(0, 10'h055);
        req_valid = 4'b0001;
        repeat (3) step();
        idle(4);

        // Address boundary: 0x3FF then 0x000.
        set_addr(1, 10'h3FF);
        req_valid = 4'b0010;
        step();
        set_addr(1, 10'h000);
        req_valid = 4'b0010;
        step();
        idle(4);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    set_addr(i, pick_addr());
                    req_valid[i] = 1'b1;
                end
            end
            if ($urandom_range(99, 0) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
